// File: rtl/alu_accum_seq.sv
// Accumulator ALU with valid/ready operation handshake, a shift-add multiplier
// and an OFF/READY/RUN/ERROR control FSM with a sticky overflow flag.
module alu_accum_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic             src_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2, OP_NOT  = 3'd3,
    OP_ADD = 3'd4, OP_SUB = 3'd5, OP_MUL = 3'd6, OP_LOAD = 3'd7
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               rv_q, rv_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;

  assign op_ready  = (state_q == S_READY) && on;
  assign accept    = op_ready && op_valid;
  assign op_a      = src_sel ? num1 : acc_q;
  assign sum       = {1'b0, op_a} + {1'b0, num2};
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  assign result    = acc_q;
  assign res_valid = rv_q;
  assign overflow  = ovf_q;
  assign state     = state_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_OFF: begin
        if (on) state_d = S_READY;
      end

      S_READY: begin
        if (accept) begin
          ovf_d = 1'b0;
          if (op_code == OP_MUL) begin
            // Operands are latched here so later input changes cannot disturb the multiply.
            state_d  = S_RUN;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = num2;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            rv_d = 1'b1;
            unique case (op_code)
              OP_AND:  acc_d = op_a & num2;
              OP_OR:   acc_d = op_a | num2;
              OP_XOR:  acc_d = op_a ^ num2;
              OP_NOT:  acc_d = ~op_a;
              OP_ADD: begin
                acc_d = sum[WIDTH-1:0];
                ovf_d = sum[WIDTH];
              end
              OP_SUB: begin
                acc_d = op_a - num2;
                ovf_d = (op_a < num2);
              end
              default: acc_d = num1;
            endcase
          end
        end else if (!on) begin
          state_d = S_OFF;
        end
      end

      S_RUN: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          acc_d = prod_step[WIDTH-1:0];
          rv_d  = 1'b1;
          if (|prod_step[2*WIDTH-1:WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            state_d = S_READY;
          end
        end
      end

      default: begin
        state_d = on ? S_READY : S_OFF;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      rv_q     <= rv_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
